// File: rtl/matrix_result_uart_tx.sv
// matrix_result_uart_tx: captures a matrix_mult result on the rising edge of done and
// streams its elements, element 0 first, as 8N1 UART frames on TxD.
module matrix_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 9,
  parameter int BYTE_W       = 8
) (
  input  logic                          Clock,
  input  logic                          reset_n,
  input  logic                          done,
  input  logic [NUM_BYTES*BYTE_W-1:0]   C,
  output logic                          TxD,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam int IW = BYTE_W > 1 ? $clog2(BYTE_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                        state_q;
  logic                          done_q;
  logic [NUM_BYTES*BYTE_W-1:0]   shadow_q;
  logic [CW-1:0]                 cnt_q;
  logic [IW-1:0]                 bit_idx_q;
  logic [BW-1:0]                 byte_idx_q;
  logic                          trig;
  logic                          bit_end;
  logic                          last_byte;
  logic [BYTE_W-1:0]             cur;

  assign trig      = done & ~done_q;
  assign bit_end   = cnt_q == CNT_LAST;
  assign last_byte = byte_idx_q == BW'(NUM_BYTES - 1);
  assign cur       = shadow_q[byte_idx_q*BYTE_W +: BYTE_W];

  // done_q resets high so a done level held through reset is not seen as an edge
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      done_q     <= 1'b1;
      shadow_q   <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      TxD        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_q     <= done;
      overrun    <= trig && state_q != IDLE;
      frame_done <= 1'b0;
      cnt_q      <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (trig) begin
          shadow_q   <= C;
          byte_idx_q <= '0;
          state_q    <= START;
          TxD        <= 1'b0;
          busy       <= 1'b1;
        end
        START: if (bit_end) begin
          state_q   <= DATA;
          bit_idx_q <= '0;
          TxD       <= cur[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx_q == IW'(BYTE_W - 1)) begin
            state_q <= STOP;
            TxD     <= 1'b1;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            TxD       <= cur[bit_idx_q + 1'b1];
          end
        end
        STOP: begin
          // registered one cycle early so the pulse lands on the final stop-bit cycle
          frame_done <= last_byte && cnt_q == CNT_PRE;
          if (bit_end) begin
            if (last_byte) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state_q    <= START;
              TxD        <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_uart_tx.sv
// tb_matrix_result_uart_tx: directed bench with a UART monitor checking decoded bytes
// against a scoreboard queue filled at each accepted trigger.
module tb_matrix_result_uart_tx;
  localparam int N = 4;

  logic        Clock = 1'b0;
  logic        reset_n;
  logic        done;
  logic [71:0] C;
  logic        TxD, busy, frame_done, overrun;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int gen    = 0;
  logic [7:0] q[$];

  always #5 Clock = ~Clock;

  matrix_result_uart_tx #(.CLKS_PER_BIT(N), .NUM_BYTES(9), .BYTE_W(8)) dut (
    .Clock(Clock), .reset_n(reset_n), .done(done), .C(C),
    .TxD(TxD), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [71:0] c);
    for (int k = 0; k < 9; k++) q.push_back(c[8*k +: 8]);
  endtask

  // returns on the first start-bit cycle of the accepted frame
  task automatic trigger(input logic [71:0] c);
    C = c;
    push(c);
    done = 1'b0;
    @(negedge Clock);
    done = 1'b1;
    @(negedge Clock);
  endtask

  task automatic frame_watch(input int drop_at, input int rise_at, input logic [71:0] cnew,
                             input int cchg_at, output int fd_at, output int busy_bad,
                             output int ovr_n, output logic [43:0] tx);
    fd_at = -1;
    busy_bad = 0;
    ovr_n = 0;
    tx = '0;
    for (int i = 0; i < 361; i++) begin
      if (i > 0) @(negedge Clock);
      if (i < 44) tx[i] = TxD;
      if (frame_done === 1'b1) fd_at = (fd_at < 0) ? i : -2;
      if (overrun === 1'b1) ovr_n++;
      if (busy !== (i < 360)) busy_bad++;
      if (i == drop_at) done = 1'b0;
      if (i == rise_at) done = 1'b1;
      if (i == cchg_at) C = cnew;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic       stp;
    int         g;
    forever begin
      @(negedge Clock);
      if (reset_n === 1'b1 && TxD === 1'b0) begin
        g = gen;
        repeat (2) @(negedge Clock);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge Clock);
          b[k] = TxD;
        end
        repeat (4) @(negedge Clock);
        stp = TxD;
        @(negedge Clock);
        if (g == gen) begin
          chk("stop_bit", 64'(stp), 64'd1);
          chk("byte_expected", 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) chk("rx_byte", 64'(b), 64'(q.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    int          fd, bb, on, cnt;
    logic [43:0] tx, exp_tx;
    logic [7:0]  e0;
    reset_n = 1'b1;
    done = 1'b0;
    C = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_txd", 64'(TxD), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge Clock);
    reset_n = 1'b1;
    repeat (3) @(negedge Clock);

    trigger(72'h09_08_07_06_05_04_03_02_01);
    chk("start_txd", 64'(TxD), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    frame_watch(2, -1, '0, -1, fd, bb, on, tx);
    chk("basic_fd_at", 64'(fd), 64'd359);
    chk("basic_busy_window", 64'(bb), 64'd0);
    chk("basic_no_overrun", 64'(on), 64'd0);

    trigger(72'h11_22_33_44_55_66_77_3C_A5);
    frame_watch(2, -1, '0, -1, fd, bb, on, tx);
    e0 = 8'hA5;
    for (int i = 0; i < 44; i++)
      exp_tx[i] = (i / 4 == 0 || i / 4 == 10) ? 1'b0 : (i / 4 == 9) ? 1'b1 : e0[i/4 - 1];
    chk("bit_sequence", 64'(tx), 64'(exp_tx));
    chk("bit_fd_at", 64'(fd), 64'd359);

    trigger(72'h99_88_77_66_55_44_33_22_11);
    frame_watch(-1, -1, '0, -1, fd, bb, on, tx);
    chk("hold_fd_at", 64'(fd), 64'd359);
    cnt = 0;
    repeat (640) begin
      @(negedge Clock);
      if (busy !== 1'b0) cnt++;
    end
    chk("hold_single_frame", 64'(cnt), 64'd0);

    trigger(72'hDE_AD_BE_EF_01_23_45_67_89);
    frame_watch(2, 100, 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF, 50, fd, bb, on, tx);
    chk("overrun_pulses", 64'(on), 64'd1);
    chk("overrun_fd_at", 64'(fd), 64'd359);
    chk("overrun_busy_window", 64'(bb), 64'd0);

    trigger(72'h5A_C3_0F_F0_81_7E_42_24_18);
    frame_watch(2, 360, '0, -1, fd, bb, on, tx);
    push(C);
    chk("b2b_first_no_overrun", 64'(on), 64'd0);
    @(negedge Clock);
    chk("b2b_start_txd", 64'(TxD), 64'd0);
    chk("b2b_start_busy", 64'(busy), 64'd1);
    frame_watch(2, -1, '0, -1, fd, bb, on, tx);
    chk("b2b_second_fd_at", 64'(fd), 64'd359);
    chk("b2b_second_no_overrun", 64'(on), 64'd0);

    trigger(72'h12_34_56_78_9A_BC_DE_F0_55);
    repeat (130) @(negedge Clock);
    reset_n = 1'b0;
    gen++;
    q.delete();
    #1;
    chk("midrst_txd", 64'(TxD), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge Clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge Clock);
      if (busy !== 1'b0) cnt++;
    end
    chk("done_high_through_reset", 64'(cnt), 64'd0);
    trigger(72'hA1_B2_C3_D4_E5_F6_07_18_29);
    frame_watch(2, -1, '0, -1, fd, bb, on, tx);
    chk("post_reset_fd_at", 64'(fd), 64'd359);
    repeat (5) @(negedge Clock);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
